// File: rtl/arb_rr_8.sv
// ---------------------------------------------------------------------------
// arb_rr_8 -- eight-requester rotating-priority arbiter with grant hold.
//
// Shares one downstream resource among eight clients. The current owner
// keeps the grant for as long as it holds its request. When it drops the
// request, the next owner is picked in the same edge, so there is no bubble
// cycle. Priority rotates so that the last winner becomes lowest priority.
// Right after reset the pointer sits at 7, so arbitration matches a plain
// MSB-first priority encoder.
//
// Optional feature (compile-time macro ARB_MAX_HOLD_EN):
//   Defined   : a hold counter limits each owner to HOLD_MAX consecutive
//               cycles while another client is waiting. When the limit
//               forces a release, timeout pulses for one cycle.
//   Undefined : no counter is built, timeout is tied low, HOLD_MAX unused.
//
// Parameters:
//   HOLD_MAX   maximum consecutive grant cycles per owner (1..255)
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  asynchronous active-high reset
//   req        in   8  request vector, bit i belongs to client i
//   gnt        out  8  registered one-hot grant, zero when idle
//   gnt_id     out  3  registered binary owner index (valid with gnt_valid)
//   gnt_valid  out  1  registered, high whenever gnt is non-zero
//   timeout    out  1  one-cycle pulse after a forced release
// ---------------------------------------------------------------------------
module arb_rr_8 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;

    logic       force_rel;
    logic [7:0] arb_mask;
    logic [7:0] rot;
    logic [2:0] sel;
    logic [2:0] arb_win;
    logic       arb_any;
    logic       do_arb;

`ifdef ARB_MAX_HOLD_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // The owner is pushed out only when it has used up its hold budget
    // and someone else is actually waiting; it is then masked out so the
    // re-arbitration cannot hand the grant straight back to it.
    always_comb begin
        force_rel = (state_q == GRANT) && req[gnt_id_q] &&
                    (cnt_q == CNT_MAX) && (|(req & ~gnt_q));
        arb_mask  = force_rel ? (req & ~gnt_q) : req;
    end
`else
    // HOLD_MAX has no effect in this build.
    logic [7:0] unused_hold_max;
    assign unused_hold_max = 8'(HOLD_MAX);

    // Without the hold limit an owner is never pushed out.
    always_comb begin
        force_rel = 1'b0;
        arb_mask  = req;
    end
`endif

    // Rotate the masked requests so that index ptr lands on bit 7. Then the
    // fixed MSB-first search finds the winner, and the result is rotated
    // back by adding ptr+1 (mod 8).
    always_comb begin
        rot = 8'({arb_mask, arb_mask} >> (4'(ptr_q) + 4'd1));
        sel = 3'd0;
        for (int j = 0; j < 8; j++) begin
            if (rot[j]) begin
                sel = 3'(j);
            end
        end
        arb_any = |arb_mask;
        arb_win = ptr_q + sel + 3'd1;
    end

    // State register: every piece of arbiter state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd7;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
`ifdef ARB_MAX_HOLD_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
`ifdef ARB_MAX_HOLD_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    // Next-state logic. Re-arbitration happens on a fresh request from
    // IDLE, when the owner drops its request, or on a forced release. The
    // winner's index minus one becomes the new pointer, so the winner
    // becomes lowest priority next time. gnt_id keeps its old value when
    // the arbiter goes idle.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        do_arb      = 1'b0;
`ifdef ARB_MAX_HOLD_EN
        cnt_d       = cnt_q;
        timeout_d   = force_rel;
`endif
        case (state_q)
            IDLE: begin
                do_arb = |req;
            end
            GRANT: begin
                if (!req[gnt_id_q] || force_rel) begin
                    do_arb = 1'b1;
                end else begin
`ifdef ARB_MAX_HOLD_EN
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
            end
            default: begin
                do_arb = 1'b0;
            end
        endcase

        if (do_arb) begin
            if (arb_any) begin
                state_d     = GRANT;
                gnt_d       = 8'd1 << arb_win;
                gnt_id_d    = arb_win;
                gnt_valid_d = 1'b1;
                ptr_d       = arb_win - 3'd1;
`ifdef ARB_MAX_HOLD_EN
                cnt_d       = CNT_W'(1);
`endif
            end else begin
                state_d     = IDLE;
                gnt_d       = 8'd0;
                gnt_valid_d = 1'b0;
`ifdef ARB_MAX_HOLD_EN
                cnt_d       = '0;
`endif
            end
        end
    end

    // Outputs come straight from registers, so there is no combinational
    // path from req to any output.
    always_comb begin
        gnt       = gnt_q;
        gnt_id    = gnt_id_q;
        gnt_valid = gnt_valid_q;
`ifdef ARB_MAX_HOLD_EN
        timeout   = timeout_q;
`else
        timeout   = 1'b0;
`endif
    end

endmodule

// File: doc/arb_rr_8.md
# arb_rr_8

Eight-requester rotating-priority arbiter with grant hold, used to share one downstream resource (bus, port or functional unit) among eight clients. It wraps the team's MSB-first 8-to-3 priority encoding with a rotating priority pointer, registered one-hot and binary grants, and an optional hold-time limit. After reset it arbitrates exactly like the fixed MSB-first encoder, and priority rotates from there.

## Interface
- HOLD_MAX, 16: maximum consecutive grant cycles per owner when the hold limit is compiled in. Legal range 1..255.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  8  request vector; bit i is client i; a client holds it high for as long as it needs the resource
- gnt  out  8  one-hot grant, registered; all zero when idle
- gnt_id  out  3  binary index of the owner, registered; valid only while gnt_valid = 1
- gnt_valid  out  1  registered; 1 whenever gnt is non-zero
- timeout  out  1  one-cycle pulse when an owner was force-released; constant 0 when ARB_MAX_HOLD_EN is undefined

## Operation
- State: IDLE or GRANT; ptr[2:0] is the highest-priority index; cnt is the hold counter, width $clog2(HOLD_MAX+1).
- Priority order: ptr, ptr-1, …, 0, 7, …, ptr+1 (descending, mod 8).
- When a client k is granted, ptr becomes k-1 mod 8, so k becomes lowest priority.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise, at the edge, grant the first set bit in priority order: gnt = 1<<k, gnt_id = k, gnt_valid = 1, cnt = 1.
  - Then go to GRANT.
- GRANT, owner k:
  - **Owner still requesting, not forced:** if req[k] = 1 and no forced release applies, hold the grant. cnt increments and saturates at HOLD_MAX.
  - **Owner drops its request:** if req[k] = 0, re-arbitrate at the same edge over the current req, with no bubble cycle.
    - If any request is pending, grant the new winner and set cnt = 1.
    - If none is pending, go to IDLE and clear gnt, gnt_valid and cnt.
  - **Forced release** (ARB_MAX_HOLD_EN only): applies when cnt == HOLD_MAX and req has any bit set other than k.
    - Re-arbitrate over req with bit k masked off.
    - Set timeout = 1 for the next cycle.
    - If no other request is pending, the owner keeps the grant indefinitely.
- gnt_id holds its last value in IDLE; consumers ignore it there.
- Requests that rise while a grant is held wait; they are never lost as long as they stay high.
- Reset (asynchronous, any time, including mid-grant):
  - State = IDLE, ptr = 7, cnt = 0.
  - gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0.

## Timing
- Request to grant: 1 cycle. req sampled at edge N produces gnt visible after edge N.
- Handover: owner deasserts req in cycle N, and the next owner's gnt is visible after edge N; gnt is never high for two clients at once.
- The releasing client sees its gnt drop in the same cycle that the new gnt rises.
- Forced release: the owner holds exactly HOLD_MAX cycles; the new grant and timeout appear in cycle HOLD_MAX+1.
- HOLD_MAX = 1 with contention gives strict one-cycle round-robin.
- The owner that drops and re-raises req in consecutive cycles competes at lowest priority.
- No combinational path from req to any output.

## Configuration
- ARB_MAX_HOLD_EN defined:
  - The hold counter and forced release are built.
  - timeout is driven as described under Operation.
- ARB_MAX_HOLD_EN undefined:
  - No counter logic is built; an owner holds until it drops req.
  - timeout is tied to 0.
  - HOLD_MAX is ignored.

## Test plan
- **Reset priority:** after reset, req = 8'b0101_0010 → next cycle gnt = 8'b0100_0000, gnt_id = 6, gnt_valid = 1.
- **Rotation:** req = 8'hFF held, each owner drops req for exactly one cycle after each grant → grant order 7,6,5,4,3,2,1,0,7, with no idle cycles between grants.
- **Hold and handover:** client 2 granted, req[2] held for 10 cycles while req[5] rises at cycle 3 → gnt stays 8'h04 for 10 cycles, then 8'h20 the next cycle.
- **Idle return:** single owner drops req with req otherwise 0 → gnt = 0 and gnt_valid = 0 after the edge; a later req[0] yields gnt_id = 0 one cycle later.
- **Forced release** (ARB_MAX_HOLD_EN, HOLD_MAX = 4): req[7] and req[1] held continuously → client 7 gets 4 cycles, then client 1 gets 4 cycles, alternating; timeout pulses on each switch.
  - Same test with only req[7] high → client 7 holds indefinitely and timeout stays 0.
- **Async reset mid-grant:** assert rst while gnt = 8'h08 → all outputs are 0 immediately, without waiting for a clock edge. After release with req = 8'h09, gnt_id = 3.
